// File: rtl/inst_rom_loader_pkg.sv
// Shared definitions for the boot-time instruction ROM loader:
// FSM state encodings and the default instruction-memory depth.
package inst_rom_loader_pkg;

  // log2 of the instruction-memory depth in 32-bit words.
  localparam int InstMemNumLog2 = 17;

  // Frame parser states; S_DONE and S_ERR only leave on reset.
  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  // True in every state that consumes stream bytes.
  function automatic logic accepts_bytes(input state_e s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA) || (s == S_CHK);
  endfunction

endpackage

// File: rtl/inst_rom_loader.sv
// Boot-time loader: parses a framed byte stream (16-bit word count, big-endian
// instruction words, XOR checksum), writes each word into instruction memory
// and keeps the CPU core in reset until a checksum-valid image is in place.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int ADDR_W = InstMemNumLog2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_waddr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  // Largest legal word count; 33 bits so the comparison never overflows.
  localparam logic [32:0] MaxWords = 33'd1 << ADDR_W;

  state_e            state_q;
  logic [15:0]       len_q;
  // One bit wider than the address so a full-memory image ends without wrap.
  logic [ADDR_W:0]   word_cnt_q;
  logic [1:0]        byte_cnt_q;
  // Only the three earlier bytes of a word need storing; the fourth is
  // taken straight from in_data when the word is written.
  logic [23:0]       asm_q;
  logic [7:0]        chk_q;
  logic              rom_we_q;
  logic [ADDR_W-1:0] rom_waddr_q;
  logic [31:0]       rom_wdata_q;
  logic              cpu_rst_q;
  logic              load_done_q;
  logic              load_err_q;

  logic              xfer;
  logic [15:0]       len_d;
  logic [ADDR_W:0]   word_cnt_d;
  logic              last_word;

  // Handshake and next-value helpers; rst gates in_ready so no byte is
  // consumed while the loader is being reset.
  assign in_ready   = ~rst & accepts_bytes(state_q);
  assign xfer       = in_valid & in_ready;
  assign len_d      = {len_q[15:8], in_data};
  assign word_cnt_d = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word  = (33'(word_cnt_d) == 33'(len_q));

  // Frame parser with registered ROM-write and status outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    if (rst) begin
      state_q     <= S_LEN_HI;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      chk_q       <= '0;
      rom_we_q    <= 1'b0;
      rom_waddr_q <= '0;
      rom_wdata_q <= '0;
      cpu_rst_q   <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      rom_we_q <= 1'b0;
      if (xfer) begin
        unique case (state_q)
          S_LEN_HI: begin
            len_q[15:8] <= in_data;
            state_q     <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len_q      <= len_d;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            chk_q      <= '0;
            if (33'(len_d) > MaxWords) begin
              state_q    <= S_ERR;
              load_err_q <= 1'b1;
            end else if (len_d == 16'd0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            asm_q      <= {asm_q[15:0], in_data};
            chk_q      <= chk_q ^ in_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              rom_we_q    <= 1'b1;
              rom_waddr_q <= word_cnt_q[ADDR_W-1:0];
              rom_wdata_q <= {asm_q, in_data};
              word_cnt_q  <= word_cnt_d;
              if (last_word) begin
                state_q <= S_CHK;
              end
            end
          end
          S_CHK: begin
            if (in_data == chk_q) begin
              state_q     <= S_DONE;
              cpu_rst_q   <= 1'b0;
              load_done_q <= 1'b1;
            end else begin
              state_q    <= S_ERR;
              load_err_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign rom_we    = rom_we_q;
  assign rom_waddr = rom_waddr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader with a 16-word instruction memory.
module tb_inst_rom_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          rom_we;
  logic [AW-1:0] rom_waddr;
  logic [31:0]   rom_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          load_err;

  inst_rom_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .rom_we    (rom_we),
    .rom_waddr (rom_waddr),
    .rom_wdata (rom_wdata),
    .cpu_rst   (cpu_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Observed ROM writes, captured mid-cycle.
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  // Expected ROM writes for the current scenario.
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  // Byte stream for the current scenario.
  logic [7:0]    frame[$];

  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      wr_addr.push_back(rom_waddr);
      wr_data.push_back(rom_wdata);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds rst for the given cycles, checks reset values, releases it and
  // clears the write log.
  task automatic do_reset(input int cycles);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (cycles) tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_rom_we", 32'(rom_we), 32'd0);
    check("rst_status", {30'd0, load_done, load_err}, 32'd0);
    check("rst_waddr_wdata", rom_wdata | 32'(rom_waddr), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(in_ready), 32'd1);
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Offers one byte after 'gap' idle cycles and waits, bounded, for it to be taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit sent = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'hA5;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 16 && !sent; n++) begin
      if (in_ready) sent = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("send_byte_accepted", 32'(sent), 32'd1);
  endtask

  task automatic send_frame(input int max_gap);
    foreach (frame[i]) send_byte(frame[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_write_count"}, 32'(wr_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < wr_addr.size() && i < exp_addr.size(); i++) begin
      check({tag, "_waddr"}, 32'(wr_addr[i]), 32'(exp_addr[i]));
      check({tag, "_wdata"}, wr_data[i], exp_data[i]);
    end
  endtask

  task automatic load_two_word(input logic [7:0] chk);
    frame = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h00, 8'h10, 8'h34, 8'h02, 8'h00, 8'h20, chk};
    exp_addr = '{4'd0, 4'd1};
    exp_data = '{32'h3401_0010, 32'h3402_0020};
  endtask

  // One cycle of table stimulus and the outputs expected after its edge.
  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rdy;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        done;
    logic        err;
    logic        crst;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic v, input logic [7:0] d, input logic rdy, input logic we,
                     input logic [3:0] wa, input logic [31:0] wd, input logic done,
                     input logic err, input logic crst);
    vec_t r;
    r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.wa = wa; r.wd = wd;
    r.done = done; r.err = err; r.crst = crst;
    tbl.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Two-word image, back to back; XOR of the eight data bytes is 0x33.
    add(1, 8'h00, 1, 0, 4'd0, 32'h0,          0, 0, 1);
    add(1, 8'h02, 1, 0, 4'd0, 32'h0,          0, 0, 1);
    add(1, 8'h34, 1, 0, 4'd0, 32'h0,          0, 0, 1);
    add(1, 8'h01, 1, 0, 4'd0, 32'h0,          0, 0, 1);
    add(1, 8'h00, 1, 0, 4'd0, 32'h0,          0, 0, 1);
    add(1, 8'h10, 1, 1, 4'd0, 32'h3401_0010,  0, 0, 1);
    add(1, 8'h34, 1, 0, 4'd0, 32'h0,          0, 0, 1);
    add(1, 8'h02, 1, 0, 4'd0, 32'h0,          0, 0, 1);
    add(1, 8'h00, 1, 0, 4'd0, 32'h0,          0, 0, 1);
    add(1, 8'h20, 1, 1, 4'd1, 32'h3402_0020,  0, 0, 1);
    add(1, 8'h33, 1, 0, 4'd0, 32'h0,          1, 0, 0);
    add(1, 8'h00, 0, 0, 4'd0, 32'h0,          1, 0, 0);

    do_reset(3);
    foreach (tbl[i]) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      tick();
      check($sformatf("tbl%0d_rom_we", i), 32'(rom_we), 32'(tbl[i].we));
      if (tbl[i].we) begin
        check($sformatf("tbl%0d_waddr", i), 32'(rom_waddr), 32'(tbl[i].wa));
        check($sformatf("tbl%0d_wdata", i), rom_wdata, tbl[i].wd);
      end
      check($sformatf("tbl%0d_done_err_crst", i), {29'd0, load_done, load_err, cpu_rst},
            {29'd0, tbl[i].done, tbl[i].err, tbl[i].crst});
    end
    in_valid = 1'b0;
    load_two_word(8'h33);
    compare_writes("good");

    // Bad checksum: both words land, loader reports an error and stalls.
    do_reset(2);
    load_two_word(8'hFF);
    send_frame(0);
    tick();
    compare_writes("badchk");
    check("badchk_err_done", {30'd0, load_err, load_done}, 32'b10);
    check("badchk_cpu_rst", 32'(cpu_rst), 32'd1);
    check("badchk_in_ready", 32'(in_ready), 32'd0);

    // Random idle cycles between bytes: same writes, no extra strobes.
    do_reset(2);
    load_two_word(8'h33);
    send_frame(3);
    repeat (5) tick();
    compare_writes("gaps");
    check("gaps_done_crst", {30'd0, load_done, cpu_rst}, 32'b10);

    // N = 16 fills the whole memory.
    do_reset(2);
    frame = '{8'h00, 8'h10};
    exp_addr.delete();
    exp_data.delete();
    x = 8'h00;
    for (int k = 0; k < 16; k++) begin
      exp_addr.push_back(4'(k));
      exp_data.push_back({8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)});
    end
    for (int b = 0; b < 64; b++) begin
      frame.push_back(8'(b));
      x = x ^ 8'(b);
    end
    frame.push_back(x);
    send_frame(0);
    tick();
    compare_writes("n16");
    check("n16_done_err_crst", {29'd0, load_done, load_err, cpu_rst}, 32'b100);

    // N = 17 is one word too many: error right after LEN_LO, nothing written.
    do_reset(2);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    check("n17_err", 32'(load_err), 32'd1);
    check("n17_in_ready", 32'(in_ready), 32'd0);
    check("n17_cpu_rst", 32'(cpu_rst), 32'd1);
    repeat (3) tick();
    check("n17_writes", 32'(wr_addr.size()), 32'd0);

    // N = 0 with checksum 00: accepted immediately, nothing written.
    do_reset(2);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("n0_done_err_crst", {29'd0, load_done, load_err, cpu_rst}, 32'b100);
    check("n0_writes", 32'(wr_addr.size()), 32'd0);

    // Reset after six data bytes, then a complete frame.
    do_reset(2);
    frame = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    send_frame(0);
    do_reset(1);
    check("midrst_done", 32'(load_done), 32'd0);
    load_two_word(8'h33);
    send_frame(0);
    tick();
    compare_writes("midrst");
    check("midrst_done_crst", {30'd0, load_done, cpu_rst}, 32'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
